nfsr: RTL and testbench

//   24-bit nonlinear feedback shift register (NFSR) for pseudo-random bit generation.
//   A 24-bit seed is loaded in parallel. On each enabled clock the register shifts

---
 rtl/nfsr_pkg.sv | 19 +
 rtl/nfsr_feedback.sv | 24 ++
 rtl/nfsr.sv | 49 ++++
 tb/tb_nfsr.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/nfsr_pkg.sv
// Shared constants for the 24-bit nonlinear feedback shift register:
// register width, linear tap positions, AND-term taps and reset value.
package nfsr_pkg;

    localparam int NFSR_WIDTH = 24;

    // Linear (XOR) taps of the feedback function
    localparam int TAP_A = 23;
    localparam int TAP_B = 22;
    localparam int TAP_C = 21;
    localparam int TAP_D = 16;

    // Taps feeding the single nonlinear AND term
    localparam int NL_A = 12;
    localparam int NL_B = 5;

    localparam logic [NFSR_WIDTH-1:0] NFSR_RST = 24'h000000;

endpackage : nfsr_pkg

// File: rtl/nfsr_feedback.sv
// Combinational feedback function of the NFSR:
//   f = q[23] ^ q[22] ^ q[21] ^ q[16] ^ (q[12] & q[5])
// Kept in its own module so the tap set can be changed or unit-tested
// without touching the state register.
module nfsr_feedback
    import nfsr_pkg::*;
(
    input  logic [NFSR_WIDTH-1:0] q_i,
    output logic                  f_o
);

    logic linear_s;
    logic nonlin_s;
    logic unused_bits_s;

    assign linear_s = q_i[TAP_A] ^ q_i[TAP_B] ^ q_i[TAP_C] ^ q_i[TAP_D];
    assign nonlin_s = q_i[NL_A] & q_i[NL_B];
    assign f_o      = linear_s ^ nonlin_s;

    // Only six of the state bits matter to f; the rest are consumed here on
    // purpose so the full state can be passed in unchanged.
    assign unused_bits_s = ^q_i;

endmodule : nfsr_feedback

// File: rtl/nfsr.sv
// 24-bit nonlinear feedback shift register.
// Priority per rising edge: reset > parallel load > shift > hold.
// Par_out is the raw state register, Ser_out is its MSB.
module nfsr
    import nfsr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  shift_en,
    input  logic                  Par_load,
    input  logic [NFSR_WIDTH-1:0] Seed,
    output logic [NFSR_WIDTH-1:0] Par_out,
    output logic                  Ser_out
);

    logic [NFSR_WIDTH-1:0] state_q;
    logic [NFSR_WIDTH-1:0] state_d;
    logic                  fb_s;

    nfsr_feedback u_feedback (
        .q_i (state_q),
        .f_o (fb_s)
    );

    // Next-state selection: load beats shift, otherwise hold.
    always_comb begin
        state_d = state_q;
        if (Par_load) begin
            state_d = Seed;
        end else if (shift_en) begin
            state_d = {state_q[NFSR_WIDTH-2:0], fb_s};
        end else begin
            state_d = state_q;
        end
    end

    // State register; reset wins over any pending load or shift on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= NFSR_RST;
        end else begin
            state_q <= state_d;
        end
    end

    assign Par_out = state_q;
    assign Ser_out = state_q[NFSR_WIDTH-1];

endmodule : nfsr

// File: tb/tb_nfsr.sv
// Self-checking bench for nfsr: directed scenarios followed by randomized
// control/seed traffic compared against an arithmetic reference model.
module tb_nfsr;

    logic        clk;
    logic        rst;
    logic        shift_en;
    logic        Par_load;
    logic [23:0] Seed;
    logic [23:0] Par_out;
    logic        Ser_out;

    int checks_cnt;
    int errors_cnt;

    int unsigned model_state;

    nfsr dut (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .Par_load (Par_load),
        .Seed     (Seed),
        .Par_out  (Par_out),
        .Ser_out  (Ser_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: pick bit n of the state with plain arithmetic
    function automatic int unsigned bit_of(input int unsigned s, input int n);
        return (s >> n) % 2;
    endfunction

    // Reference next state for one shift: double, add feedback, wrap to 24 bits
    function automatic int unsigned model_shift(input int unsigned s);
        int unsigned f;
        f = (bit_of(s, 23) + bit_of(s, 22) + bit_of(s, 21) + bit_of(s, 16)
             + bit_of(s, 12) * bit_of(s, 5)) % 2;
        return (s * 2 + f) % 32'h0100_0000;
    endfunction

    // Reference update for one edge given the control inputs
    function automatic int unsigned model_step(input int unsigned s, input logic r,
                                               input logic ld, input logic sh,
                                               input logic [23:0] sd);
        if (r)       return 0;
        else if (ld) return int'(sd);
        else if (sh) return model_shift(s);
        else         return s;
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %06h expected %06h", tag, obs, exp);
        end
    endtask

    // Apply controls, clock one edge, update model, compare both outputs
    task automatic cycle(input string tag, input logic r, input logic ld,
                         input logic sh, input logic [23:0] sd);
        rst = r; Par_load = ld; shift_en = sh; Seed = sd;
        @(posedge clk);
        model_state = model_step(model_state, r, ld, sh, sd);
        #1;
        chk({tag, "_par"}, Par_out, model_state[23:0]);
        chk({tag, "_ser"}, {23'h0, Ser_out}, {23'h0, model_state[23]});
    endtask

    initial begin
        checks_cnt  = 0;
        errors_cnt  = 0;
        model_state = 0;
        rst = 1'b0; Par_load = 1'b0; shift_en = 1'b0; Seed = 24'h000000;
        @(negedge clk);

        // 1. Reset overrides a simultaneous load
        cycle("reset", 1'b1, 1'b1, 1'b0, 24'h123456);
        chk("reset_const", Par_out, 24'h000000);
        cycle("zero_hold", 1'b0, 1'b0, 1'b1, 24'h000000);

        // 2. Load then shift, against the published sequence
        cycle("load", 1'b0, 1'b1, 1'b0, 24'h123456);
        chk("load_const", Par_out, 24'h123456);
        cycle("sh1", 1'b0, 1'b0, 1'b1, 24'h000000);
        chk("sh1_const", Par_out, 24'h2468AC);
        chk("sh1_ser", {23'h0, Ser_out}, 24'h000000);
        cycle("sh2", 1'b0, 1'b0, 1'b1, 24'h000000);
        chk("sh2_const", Par_out, 24'h48D159);
        chk("sh2_ser", {23'h0, Ser_out}, 24'h000000);
        cycle("sh3", 1'b0, 1'b0, 1'b1, 24'h000000);
        chk("sh3_const", Par_out, 24'h91A2B3);
        chk("sh3_ser", {23'h0, Ser_out}, 24'h000001);

        // 3. Hold for 5 edges
        cycle("hload", 1'b0, 1'b1, 1'b0, 24'h2468AC);
        for (int i = 0; i < 5; i++) begin
            cycle("hold", 1'b0, 1'b0, 1'b0, 24'h5A5A5A);
            chk("hold_const", Par_out, 24'h2468AC);
        end

        // 4. Load has priority over shift
        cycle("prio", 1'b0, 1'b1, 1'b1, 24'hABCDEF);
        chk("prio_const", Par_out, 24'hABCDEF);

        // Repeated load: reloads every cycle, no shifting
        for (int i = 0; i < 3; i++) begin
            cycle("reload", 1'b0, 1'b1, 1'b1, 24'h654321);
            chk("reload_const", Par_out, 24'h654321);
        end

        // 5. Fixed points
        cycle("fz_load", 1'b0, 1'b1, 1'b0, 24'h000000);
        for (int i = 0; i < 4; i++) begin
            cycle("fz", 1'b0, 1'b0, 1'b1, 24'h000000);
            chk("fz_const", Par_out, 24'h000000);
        end
        cycle("ff_load", 1'b0, 1'b1, 1'b0, 24'hFFFFFF);
        for (int i = 0; i < 4; i++) begin
            cycle("ff", 1'b0, 1'b0, 1'b1, 24'h000000);
            chk("ff_const", Par_out, 24'hFFFFFF);
            chk("ff_ser", {23'h0, Ser_out}, 24'h000001);
        end

        // 6. Reset on the 2nd shift edge, pending load ignored, then restart
        cycle("mr_load", 1'b0, 1'b1, 1'b0, 24'h123456);
        cycle("mr_sh1", 1'b0, 1'b0, 1'b1, 24'h000000);
        cycle("mr_rst", 1'b1, 1'b1, 1'b1, 24'h777777);
        chk("mr_rst_const", Par_out, 24'h000000);
        cycle("mr_reload", 1'b0, 1'b1, 1'b0, 24'h123456);
        chk("mr_reload_const", Par_out, 24'h123456);
        cycle("mr_sh", 1'b0, 1'b0, 1'b1, 24'h000000);
        chk("mr_sh_const", Par_out, 24'h2468AC);

        // Random traffic: mostly shifts, occasional loads, holds and resets
        for (int i = 0; i < 2000; i++) begin
            int unsigned r;
            logic rr, ll, ss;
            r  = $urandom_range(0, 99);
            rr = (r < 2);
            ll = (r >= 2 && r < 10) || (r >= 95);
            ss = (r >= 10 && r < 85) || (r >= 95);
            cycle("rand", rr, ll, ss, 24'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule : tb_nfsr
